multiplexor: RTL and testbench
==============================

MULTIPLEXOR -- requirements
Module: multiplexor

Interface
REQ-001 Parameter WIDTH, default 4, sets the data-path width of every data input and of Exit.
REQ-002 i_Clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 i_Rst_n  input  1  reset; synchronous and active-low, sampled on rising i_Clk.
REQ-004 i_Datos_0  input  WIDTH  data source selected when i_Sel = 0.
REQ-005 i_Datos_1  input  WIDTH  data source selected when i_Sel = 1.
REQ-006 i_Datos_2  input  WIDTH  data source selected when i_Sel = 2.
REQ-007 i_Datos_3  input  WIDTH  data source selected when i_Sel = 3.
REQ-008 i_Sel  input  2  source select, binary-encoded.
REQ-009 Exit  output  WIDTH  registered selected data.
REQ-010 o_Sel_Q  output  2  registered copy of the i_Sel value that produced the current Exit.
REQ-011 o_Valid  output  1  high once Exit holds a post-reset sampled value.
REQ-012 o_Change  output  1  one-cycle pulse when Exit changes value.

Function
REQ-013 On each rising i_Clk with i_Rst_n = 1, Exit SHALL load i_Datos_N, where N = i_Sel sampled on the same edge.
REQ-014 Latency SHALL be exactly one clock from i_Sel or data change to Exit; no combinational input-to-output path.
REQ-015 All four i_Sel codes SHALL be valid; no illegal-select state exists.
REQ-016 o_Sel_Q SHALL load i_Sel on the same edge Exit loads, so the pair is always coherent.
REQ-017 o_Valid SHALL go high on the first rising edge with i_Rst_n = 1 and SHALL remain high until reset.
REQ-018 o_Change SHALL be high for the cycle after an edge where the newly loaded Exit differs from the previous Exit and o_Valid was already high; low otherwise.
REQ-019 Data change and select change on the same edge SHALL use the new data at the new select; no priority between them.
REQ-020 Exit SHALL track data changes on the selected input every cycle, even when i_Sel is held constant.

Reset
REQ-021 While i_Rst_n = 0 at a rising edge: Exit = 0, o_Sel_Q = 0, o_Valid = 0, o_Change = 0.
REQ-022 Reset asserted mid-operation SHALL override sampling on that edge; the first edge after release SHALL load normally with o_Change = 0.
REQ-023 Outputs are undefined before the first reset edge; no asynchronous behaviour is permitted.

Configuration
REQ-024 Macro MULTIPLEXOR_PARITY_EN: when defined, the module SHALL add output o_Parity (1 bit), registered with Exit, equal to the XOR of the loaded Exit bits; o_Parity is 0 in reset.
REQ-025 Without MULTIPLEXOR_PARITY_EN, o_Parity SHALL NOT exist and all other behaviour SHALL be identical.

Verification
REQ-026 Reset held 2 cycles with all inputs 0 -> Exit = 0, o_Sel_Q = 0, o_Valid = 0, o_Change = 0.
REQ-027 Datos_0..3 = 1, 2, 4, 8; i_Sel stepped 0, 1, 2, 3, one per cycle -> Exit = 1, 2, 4, 8 each one cycle later, o_Sel_Q matching, o_Change pulsing on each step.
REQ-028 i_Sel = 0 held; i_Datos_0 changes 0 -> 1 -> Exit = 1 one cycle later, o_Change = 1 for one cycle.
REQ-029 i_Sel = 3 with Exit = 8, then i_Rst_n = 0 for one edge -> Exit = 0, o_Valid = 0; after release, Exit = 8, o_Change = 0.
REQ-030 Datos_1 = Datos_2 = 5; i_Sel 1 -> 2 -> Exit stays 5, o_Change stays 0, o_Sel_Q = 2.
REQ-031 With MULTIPLEXOR_PARITY_EN, i_Sel selecting 7 then 3 on Datos inputs -> o_Parity = 1 then 0, aligned with Exit.

Source files
------------

// File: rtl/multiplexor.sv
// Registered 4:1 multiplexor with select echo, valid flag and change pulse.
// Define MULTIPLEXOR_PARITY_EN to add a registered even-parity bit of Exit.
module multiplexor #(
  parameter int WIDTH = 4
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  input  logic [WIDTH-1:0] i_Datos_0,
  input  logic [WIDTH-1:0] i_Datos_1,
  input  logic [WIDTH-1:0] i_Datos_2,
  input  logic [WIDTH-1:0] i_Datos_3,
  input  logic [1:0]       i_Sel,
  output logic [WIDTH-1:0] Exit,
  output logic [1:0]       o_Sel_Q,
  output logic             o_Valid,
  output logic             o_Change
`ifdef MULTIPLEXOR_PARITY_EN
  ,
  output logic             o_Parity
`endif
);

  logic [WIDTH-1:0] next_exit;

  // All four select codes map to a source, so there is no illegal-select case.
  always_comb begin
    next_exit = i_Datos_0;
    case (i_Sel)
      2'd0: next_exit = i_Datos_0;
      2'd1: next_exit = i_Datos_1;
      2'd2: next_exit = i_Datos_2;
      2'd3: next_exit = i_Datos_3;
      default: next_exit = i_Datos_0;
    endcase
  end

  // o_Change compares against the previous Exit only once a real sample exists,
  // so the first load after reset never pulses.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      Exit     <= '0;
      o_Sel_Q  <= 2'd0;
      o_Valid  <= 1'b0;
      o_Change <= 1'b0;
    end else begin
      Exit     <= next_exit;
      o_Sel_Q  <= i_Sel;
      o_Valid  <= 1'b1;
      o_Change <= o_Valid && (next_exit != Exit);
    end
  end

`ifdef MULTIPLEXOR_PARITY_EN
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n)
      o_Parity <= 1'b0;
    else
      o_Parity <= ^next_exit;
  end
`endif

endmodule

// File: tb/tb_multiplexor.sv
// Directed self-checking bench for multiplexor; parity checks are built only
// when MULTIPLEXOR_PARITY_EN is defined.
module tb_multiplexor;

  localparam int WIDTH = 4;

  logic             i_Clk = 1'b0;
  logic             i_Rst_n;
  logic [WIDTH-1:0] i_Datos_0, i_Datos_1, i_Datos_2, i_Datos_3;
  logic [1:0]       i_Sel;
  logic [WIDTH-1:0] Exit;
  logic [1:0]       o_Sel_Q;
  logic             o_Valid;
  logic             o_Change;
`ifdef MULTIPLEXOR_PARITY_EN
  logic             o_Parity;
`endif

  int checks = 0;
  int errors = 0;

  multiplexor #(.WIDTH(WIDTH)) dut (
    .i_Clk    (i_Clk),
    .i_Rst_n  (i_Rst_n),
    .i_Datos_0(i_Datos_0),
    .i_Datos_1(i_Datos_1),
    .i_Datos_2(i_Datos_2),
    .i_Datos_3(i_Datos_3),
    .i_Sel    (i_Sel),
    .Exit     (Exit),
    .o_Sel_Q  (o_Sel_Q),
    .o_Valid  (o_Valid),
    .o_Change (o_Change)
`ifdef MULTIPLEXOR_PARITY_EN
    ,
    .o_Parity (o_Parity)
`endif
  );

  always #5 i_Clk = ~i_Clk;

  // Drive one input vector, then let exactly one rising edge consume it.
  task automatic applyStimulus(input logic rst_n, input logic [1:0] sel,
                               input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                               input logic [WIDTH-1:0] d2, input logic [WIDTH-1:0] d3);
    i_Rst_n   = rst_n;
    i_Sel     = sel;
    i_Datos_0 = d0;
    i_Datos_1 = d1;
    i_Datos_2 = d2;
    i_Datos_3 = d3;
    @(posedge i_Clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic checkAll(input string tag, input int e_exit, input int e_sel,
                          input int e_valid, input int e_change);
    checkOutput({tag, " exit"},   int'(Exit),     e_exit);
    checkOutput({tag, " sel_q"},  int'(o_Sel_Q),  e_sel);
    checkOutput({tag, " valid"},  int'(o_Valid),  e_valid);
    checkOutput({tag, " change"}, int'(o_Change), e_change);
  endtask

  initial begin
    // Reset two cycles, all inputs zero
    applyStimulus(1'b0, 2'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    applyStimulus(1'b0, 2'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    checkAll("reset", 0, 0, 0, 0);
`ifdef MULTIPLEXOR_PARITY_EN
    checkOutput("reset parity", int'(o_Parity), 0);
`endif

    // Walk the select through one-hot sources; first load after reset never pulses
    applyStimulus(1'b1, 2'd0, 4'd1, 4'd2, 4'd4, 4'd8);
    checkAll("sel0", 1, 0, 1, 0);
    applyStimulus(1'b1, 2'd1, 4'd1, 4'd2, 4'd4, 4'd8);
    checkAll("sel1", 2, 1, 1, 1);
    applyStimulus(1'b1, 2'd2, 4'd1, 4'd2, 4'd4, 4'd8);
    checkAll("sel2", 4, 2, 1, 1);
    applyStimulus(1'b1, 2'd3, 4'd1, 4'd2, 4'd4, 4'd8);
    checkAll("sel3", 8, 3, 1, 1);
    applyStimulus(1'b1, 2'd3, 4'd1, 4'd2, 4'd4, 4'd8);
    checkAll("sel3 hold", 8, 3, 1, 0);

    // Mid-operation reset for one edge, then release reloads without a pulse
    applyStimulus(1'b0, 2'd3, 4'd1, 4'd2, 4'd4, 4'd8);
    checkAll("mid reset", 0, 0, 0, 0);
    applyStimulus(1'b1, 2'd3, 4'd1, 4'd2, 4'd4, 4'd8);
    checkAll("release", 8, 3, 1, 0);

    // Data tracking with select held at 0
    applyStimulus(1'b1, 2'd0, 4'd0, 4'd2, 4'd4, 4'd8);
    checkAll("d0=0", 0, 0, 1, 1);
    applyStimulus(1'b1, 2'd0, 4'd0, 4'd2, 4'd4, 4'd8);
    checkAll("d0=0 hold", 0, 0, 1, 0);
    applyStimulus(1'b1, 2'd0, 4'd1, 4'd2, 4'd4, 4'd8);
    checkAll("d0=1", 1, 0, 1, 1);
    applyStimulus(1'b1, 2'd0, 4'd1, 4'd2, 4'd4, 4'd8);
    checkAll("d0=1 hold", 1, 0, 1, 0);

    // Equal data on two sources: select change without value change
    applyStimulus(1'b1, 2'd1, 4'd1, 4'd5, 4'd5, 4'd8);
    checkAll("eq sel1", 5, 1, 1, 1);
    applyStimulus(1'b1, 2'd2, 4'd1, 4'd5, 4'd5, 4'd8);
    checkAll("eq sel2", 5, 2, 1, 0);

    // Select and data change on the same edge use new data at new select
    applyStimulus(1'b1, 2'd3, 4'd1, 4'd5, 4'd5, 4'd9);
    checkAll("simul", 9, 3, 1, 1);
    applyStimulus(1'b1, 2'd0, 4'd15, 4'd5, 4'd5, 4'd9);
    checkAll("simul2", 15, 0, 1, 1);

`ifdef MULTIPLEXOR_PARITY_EN
    applyStimulus(1'b1, 2'd0, 4'd7, 4'd3, 4'd0, 4'd0);
    checkOutput("parity 7 exit", int'(Exit), 7);
    checkOutput("parity 7", int'(o_Parity), 1);
    applyStimulus(1'b1, 2'd1, 4'd7, 4'd3, 4'd0, 4'd0);
    checkOutput("parity 3 exit", int'(Exit), 3);
    checkOutput("parity 3", int'(o_Parity), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
